// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
//   Shared definitions for the datapath lab arithmetic blocks.
//   - state_t   : FSM encoding used by the sequential multiplier
//   - OP_W      : operand width of the ripple-carry adder and multiplier
//   - MUL_ITER  : number of shift-and-add iterations per multiplication
// ---------------------------------------------------------------------------
package arith_pkg;

   localparam int OP_W     = 4;
   localparam int MUL_ITER = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : arith_pkg

// File: rtl/rca_4bit.sv
// ---------------------------------------------------------------------------
// rca_4bit
//   4-bit ripple-carry adder built from a chain of full adders.
//   Ports:
//     x, y   in  4  addends
//     c_in   in  1  carry into bit 0
//     sum    out 4  low four bits of x + y + c_in
//     c_out  out 1  carry out of bit 3
// ---------------------------------------------------------------------------
module rca_4bit (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       c_in,
   output logic [3:0] sum,
   output logic       c_out
);

   logic [4:0] carry;

   assign carry[0] = c_in;

   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign sum[i]     = x[i] ^ y[i] ^ carry[i];
      assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
   end

   assign c_out = carry[4];

endmodule : rca_4bit

// File: rtl/mul_4bit_seq.sv
// ---------------------------------------------------------------------------
// mul_4bit_seq
//   Sequential 4x4 unsigned shift-and-add multiplier using rca_4bit.
//   A start pulse in IDLE captures a and b; four iterations later the
//   8-bit product is registered and done pulses for one cycle.
//   Ports:
//     clk      in  1  rising-edge clock
//     rst_n    in  1  asynchronous active-low reset
//     start    in  1  request, only honoured in IDLE
//     a        in  4  multiplicand (unsigned)
//     b        in  4  multiplier (unsigned)
//     product  out 8  registered a*b, held until next completion or reset
//     busy     out 1  high while iterations are in progress
//     done     out 1  one-cycle pulse when product is updated
// ---------------------------------------------------------------------------
module mul_4bit_seq
   import arith_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic [2*OP_W-1:0] product,
   output logic              busy,
   output logic              done
);

   // Counter value on the final iteration.
   localparam logic [1:0] LAST_ITER = 2'(MUL_ITER - 1);

   state_t            state_q, state_d;
   logic [OP_W-1:0]   m_q,   m_d;
   logic [OP_W-1:0]   acc_q, acc_d;
   logic [OP_W-1:0]   q_q,   q_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [2*OP_W-1:0] product_q, product_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // Adder hookup: add the multiplicand only when the current multiplier
   // LSB is set.
   logic [OP_W-1:0] add_y;
   logic [OP_W-1:0] add_sum;
   logic            add_c_out;

   // Accumulator/multiplier pair after one iteration: a 9-bit right shift
   // with the adder carry entering at the top, so no carry is ever lost.
   logic [2*OP_W-1:0] shifted;

   assign add_y   = q_q[0] ? m_q : '0;
   assign shifted = {add_c_out, add_sum, q_q[OP_W-1:1]};

   rca_4bit u_rca (
      .x     (acc_q),
      .y     (add_y),
      .c_in  (1'b0),
      .sum   (add_sum),
      .c_out (add_c_out)
   );

   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      acc_d     = acc_q;
      q_d       = q_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CALC;
               m_d     = a;
               q_d     = b;
               acc_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end

         CALC: begin
            {acc_d, q_d} = shifted;
            cnt_d        = cnt_q + 2'd1;
            if (cnt_q == LAST_ITER) begin
               state_d   = DONE;
               product_d = shifted;
               done_d    = 1'b1;
            end else begin
               busy_d = 1'b1;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         m_q       <= '0;
         acc_q     <= '0;
         q_q       <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         acc_q     <= acc_d;
         q_q       <= q_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign product = product_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule : mul_4bit_seq
